// File: rtl/nios2_ram_pkg.sv
// Shared constants and types for the Nios II on-chip RAM arbiter.
// The owner id and the read-return tag are used by both the arbiter and the top.
package nios2_ram_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 10240;

   typedef enum logic {
      OWN0 = 1'b0,
      OWN1 = 1'b1
   } owner_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
      logic   oob;
   } rd_tag_t;

endpackage

// File: rtl/nios2_rr_arbiter_2.sv
// Two-requester round-robin arbiter with a bounded hold window.
// The current owner keeps the RAM for up to HOLD_MAX cycles while the other master waits.
module nios2_rr_arbiter_2
   import nios2_ram_pkg::*;
#(
   parameter int HOLD_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   output logic grant0,
   output logic grant1
);

   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

   owner_t     owner_q, owner_d;
   logic [3:0] hold_q, hold_d;
   logic       own_req, oth_req;
   logic       gnt_own, gnt_oth;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= OWN0;
         hold_q  <= 4'd0;
      end else begin
         owner_q <= owner_d;
         hold_q  <= hold_d;
      end
   end

   // NOTE: every output of a combinational block gets a default first so no
   // path through the block can infer a latch.
   always_comb begin
      owner_d = owner_q;
      hold_d  = hold_q;
      if (gnt_own) begin
         if (hold_q != 4'hF) hold_d = hold_q + 4'd1;
      end else if (gnt_oth) begin
         owner_d = (owner_q == OWN0) ? OWN1 : OWN0;
         hold_d  = 4'd1;
      end
   end

   // A sole requester always wins; the window only matters under contention.
   always_comb begin
      own_req = (owner_q == OWN0) ? req0 : req1;
      oth_req = (owner_q == OWN0) ? req1 : req0;
      gnt_own = ~reset & own_req & (~oth_req | (hold_q < HOLD_LIM));
      gnt_oth = ~reset & oth_req & ~gnt_own;
      grant0  = (owner_q == OWN0) ? gnt_own : gnt_oth;
      grant1  = (owner_q == OWN0) ? gnt_oth : gnt_own;
   end

endmodule

// File: rtl/nios2_ram_arbiter.sv
// Shares the single-port program/data RAM between the Nios II data master (m0)
// and a DMA/debug master (m1), routes read data back and flags out-of-range accesses.
module nios2_ram_arbiter
   import nios2_ram_pkg::*;
#(
   parameter int ADDR_W   = nios2_ram_pkg::ADDR_W,
   parameter int DATA_W   = nios2_ram_pkg::DATA_W,
   parameter int DEPTH    = nios2_ram_pkg::DEPTH,
   parameter int HOLD_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     ram_address,
   output logic [DATA_W/8-1:0]   ram_byteenable,
   output logic [DATA_W-1:0]     ram_writedata,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic                  ram_clken,
   input  logic [DATA_W-1:0]     ram_readdata,
   output logic                  err_oob
);

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   logic              req0, req1, gnt0, gnt1, gnt_any;
   logic              sel_wr, in_range, acc_rd, rdv0, rdv1;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] rd_data;
   rd_tag_t           tag_q;
   logic              err_q;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   nios2_rr_arbiter_2 #(.HOLD_MAX(HOLD_MAX)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req0   (req0),
      .req1   (req1),
      .grant0 (gnt0),
      .grant1 (gnt1)
   );

   // Read+write together counts as a write; out-of-range accesses are accepted but never reach the RAM.
   always_comb begin
      gnt_any        = gnt0 | gnt1;
      sel_addr       = gnt1 ? m1_address : m0_address;
      sel_wr         = gnt1 ? m1_write : m0_write;
      in_range       = {1'b0, sel_addr} < DEPTH_LIM;
      acc_rd         = gnt_any & ~sel_wr;
      ram_address    = sel_addr;
      ram_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
      ram_writedata  = gnt1 ? m1_writedata : m0_writedata;
      ram_chipselect = gnt_any & in_range;
      ram_write      = gnt_any & sel_wr & in_range;
      ram_clken      = ~reset;
      m0_waitrequest = reset | (req0 & ~gnt0);
      m1_waitrequest = reset | (req1 & ~gnt1);
   end

   always_comb begin
      rdv0             = ~reset & tag_q.valid & (tag_q.owner == OWN0);
      rdv1             = ~reset & tag_q.valid & (tag_q.owner == OWN1);
      rd_data          = tag_q.oob ? '0 : ram_readdata;
      m0_readdatavalid = rdv0;
      m1_readdatavalid = rdv1;
      m0_readdata      = rdv0 ? rd_data : '0;
      m1_readdata      = rdv1 ? rd_data : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q <= '0;
         err_q <= 1'b0;
      end else begin
         tag_q <= '{valid: acc_rd, owner: (gnt1 ? OWN1 : OWN0), oob: ~in_range};
         if (gnt_any & ~in_range) err_q <= 1'b1;
      end
   end

   assign err_oob = err_q;

endmodule

// File: tb/tb_nios2_ram_arbiter.sv
// Self-checking bench: a behavioural RAM device plus a transaction-level model of
// the arbitration, memory contents and read return, compared every cycle.
module tb_nios2_ram_arbiter;
   import nios2_ram_pkg::*;

   localparam int HOLD_MAX = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [13:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [13:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic [31:0] ram_writedata, ram_readdata;
   logic        ram_chipselect, ram_write, ram_clken, err_oob;

   nios2_ram_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
      .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
      .err_oob(err_oob)
   );

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // RAM device: 1-cycle read latency, byte-enabled writes.
   logic [31:0] dev_mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (ram_clken && ram_chipselect && int'(ram_address) < DEPTH) begin
         if (ram_write) dev_mem[ram_address] <= merge(dev_mem[ram_address], ram_writedata, ram_byteenable);
         else           ram_readdata <= dev_mem[ram_address];
      end
   end

   // Reference model state.
   logic [31:0] shadow [0:DEPTH-1];
   int          turn, streak, pend_who;
   logic        pend_v, err_m;
   logic [31:0] pend_d;
   int          total = 0, bad = 0;
   int          cnt_w1, cnt_rdv1;
   logic [31:0] last_rd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic        r0, r1, wr, inr, e_rdv0, e_rdv1;
      int          g;
      logic [13:0] a;
      logic [3:0]  be;
      logic [31:0] d;
      @(negedge clk);
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      if (reset)          g = -1;
      else if (r0 && r1)  g = (streak < HOLD_MAX) ? turn : 1 - turn;
      else if (r0)        g = 0;
      else if (r1)        g = 1;
      else                g = -1;
      a   = (g == 1) ? m1_address : m0_address;
      be  = (g == 1) ? m1_byteenable : m0_byteenable;
      d   = (g == 1) ? m1_writedata : m0_writedata;
      wr  = (g == 1) ? m1_write : m0_write;
      inr = int'(a) < DEPTH;
      e_rdv0 = !reset && pend_v && pend_who == 0;
      e_rdv1 = !reset && pend_v && pend_who == 1;
      check("m0_waitrequest", m0_waitrequest, reset | (r0 & (g != 0)));
      check("m1_waitrequest", m1_waitrequest, reset | (r1 & (g != 1)));
      check("ram_chipselect", ram_chipselect, (g >= 0) & inr);
      check("ram_write", ram_write, (g >= 0) & wr & inr);
      check("ram_clken", ram_clken, !reset);
      check("m0_readdatavalid", m0_readdatavalid, e_rdv0);
      check("m1_readdatavalid", m1_readdatavalid, e_rdv1);
      check("m0_readdata", m0_readdata, e_rdv0 ? pend_d : 32'h0);
      check("m1_readdata", m1_readdata, e_rdv1 ? pend_d : 32'h0);
      check("err_oob", err_oob, err_m);
      if (g >= 0) check("ram_address", ram_address, a);
      if (g >= 0 && wr) check("ram_wdata_be", {ram_byteenable, ram_writedata[27:0]}, {be, d[27:0]});
      if (!reset && m1_waitrequest) cnt_w1++;
      if (m1_readdatavalid) cnt_rdv1++;
      last_rd0 = m0_readdata;
      @(posedge clk);
      if (reset) begin
         turn = 0; streak = 0; pend_v = 1'b0; err_m = 1'b0;
      end else begin
         pend_v = 1'b0;
         if (g >= 0) begin
            if (g == turn) streak = (streak < 15) ? streak + 1 : 15;
            else begin turn = g; streak = 1; end
            if (!inr) err_m = 1'b1;
            if (wr && inr) shadow[a] = merge(shadow[a], d, be);
            if (!wr) begin
               pend_v = 1'b1; pend_who = g; pend_d = inr ? shadow[a] : 32'h0;
            end
         end
      end
      #1;
   endtask

   task automatic drive0(input logic rd, input logic wr, input logic [13:0] a,
                         input logic [3:0] be, input logic [31:0] d);
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
   endtask

   task automatic drive1(input logic rd, input logic wr, input logic [13:0] a,
                         input logic [3:0] be, input logic [31:0] d);
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
   endtask

   function automatic logic [13:0] rand_addr();
      if ($urandom_range(0, 15) == 0) return 14'(10236 + $urandom_range(0, 7));
      return 14'(32 + $urandom_range(0, 31));
   endfunction

   initial begin
      logic [31:0] prior;
      int          k;
      for (int i = 0; i < DEPTH; i++) begin
         dev_mem[i] = $urandom;
         shadow[i]  = dev_mem[i];
      end
      ram_readdata = 32'h0;
      turn = 0; streak = 0; pend_v = 1'b0; pend_who = 0; pend_d = 32'h0; err_m = 1'b0;
      cnt_w1 = 0; cnt_rdv1 = 0;

      // Reset held with m0 reading, then release.
      reset = 1'b1;
      drive0(1'b1, 1'b0, 14'h0005, 4'hF, 32'h0);
      drive1(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
      repeat (3) tick();
      reset = 1'b0;
      tick();
      drive0(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
      tick();

      // Byte-enabled write then read back.
      prior = shadow[16];
      drive0(1'b0, 1'b1, 14'h0010, 4'b0011, 32'hA5A5_1234);
      tick();
      drive0(1'b1, 1'b0, 14'h0010, 4'hF, 32'h0);
      tick();
      drive0(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
      tick();
      check("wr_be_merge", last_rd0, {prior[31:16], 16'h1234});

      // Contention from reset: m0 x4, m1 x4, m0 x4.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         drive0(1'b1, 1'b0, 14'(100 + i), 4'hF, 32'h0);
         drive1(1'b1, 1'b0, 14'(200 + i), 4'hF, 32'h0);
         tick();
      end
      drive0(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
      drive1(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
      tick();

      // m1 alone, 20 back-to-back reads.
      cnt_w1 = 0; cnt_rdv1 = 0;
      for (int i = 0; i < 20; i++) begin
         drive1(1'b1, 1'b0, 14'(300 + i), 4'hF, 32'h0);
         tick();
      end
      drive1(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
      tick();
      check("m1_stream_waits", cnt_w1, 32'd0);
      check("m1_stream_rdv", cnt_rdv1, 32'd20);

      // Out-of-range write and reads around the boundary.
      drive1(1'b0, 1'b1, 14'h2800, 4'hF, 32'hDEAD_BEEF);
      tick();
      drive1(1'b1, 1'b0, 14'h2800, 4'hF, 32'h0);
      tick();
      drive1(1'b1, 1'b0, 14'h27FF, 4'hF, 32'h0);
      tick();
      drive1(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
      tick();
      tick();
      check("err_oob_sticky", err_oob, 1'b1);

      // Reset right after an accepted read.
      drive0(1'b1, 1'b0, 14'h0020, 4'hF, 32'h0);
      tick();
      reset = 1'b1;
      drive0(1'b1, 1'b0, 14'h0021, 4'hF, 32'h0);
      drive1(1'b1, 1'b0, 14'h0022, 4'hF, 32'h0);
      tick();
      reset = 1'b0;
      drive0(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
      drive1(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
      tick();

      // Random traffic from both masters with occasional resets.
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 63) == 0);
         k = $urandom_range(0, 3);
         drive0(k[0], k[1], rand_addr(), 4'($urandom_range(0, 15)), $urandom);
         k = $urandom_range(0, 3);
         drive1(k[0], k[1], rand_addr(), 4'($urandom_range(0, 15)), $urandom);
         tick();
      end
      reset = 1'b0;
      drive0(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
      drive1(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
